// File: rtl/time_of_day_counter_if.sv
// Signal bundle between the time-of-day counter and its neighbours:
// tick/run/load controls in, BCD time and strobes out.
interface time_of_day_counter_if;
  logic       tick;
  logic       run;
  logic       set_en;
  logic [7:0] set_hr;
  logic [7:0] set_min;
  logic [7:0] set_sec;
  logic       set_pm;
  logic [7:0] hr;
  logic [7:0] min;
  logic [7:0] sec;
  logic       pm;
  logic       day_tick;
  logic       set_err;

  modport master (
    output tick, run, set_en, set_hr, set_min, set_sec, set_pm,
    input  hr, min, sec, pm, day_tick, set_err
  );

  modport slave (
    input  tick, run, set_en, set_hr, set_min, set_sec, set_pm,
    output hr, min, sec, pm, day_tick, set_err
  );
endinterface

// File: rtl/time_of_day_counter.sv
// Time of day in packed BCD, advanced by a 1 Hz strobe, with load,
// run/hold, 12/24-hour mode and a midnight rollover strobe.
module time_of_day_counter #(
  parameter bit MODE_24H = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  time_of_day_counter_if.slave bus
);

  logic [7:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic       pm_q, pm_d, day_tick_q, day_tick_d, set_err_q, set_err_d;
  logic       tick_q, tick_d;
  logic       adv, digits_ok, hr_ok, load_ok;
  logic       c_sec_t, c_min, c_min_t, c_hr;

  always_comb begin
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    pm_d       = pm_q;
    day_tick_d = 1'b0;
    set_err_d  = 1'b0;
    tick_d     = bus.tick;

    adv = bus.tick & ~tick_q & bus.run & ~bus.set_en;

    digits_ok = (bus.set_hr[7:4]  <= 4'd9) && (bus.set_hr[3:0]  <= 4'd9) &&
                (bus.set_min[7:4] <= 4'd5) && (bus.set_min[3:0] <= 4'd9) &&
                (bus.set_sec[7:4] <= 4'd5) && (bus.set_sec[3:0] <= 4'd9);
    // Packed-BCD compares order numerically once every digit is <= 9.
    if (MODE_24H) hr_ok = (bus.set_hr <= 8'h23);
    else          hr_ok = (bus.set_hr >= 8'h01) && (bus.set_hr <= 8'h12);
    load_ok = digits_ok && hr_ok;

    c_sec_t = (sec_q[3:0] == 4'd9);
    c_min   = c_sec_t && (sec_q[7:4] == 4'd5);
    c_min_t = c_min && (min_q[3:0] == 4'd9);
    c_hr    = c_min_t && (min_q[7:4] == 4'd5);

    if (bus.set_en) begin
      if (load_ok) begin
        hr_d  = bus.set_hr;
        min_d = bus.set_min;
        sec_d = bus.set_sec;
        pm_d  = MODE_24H ? 1'b0 : bus.set_pm;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (adv) begin
      sec_d[3:0] = c_sec_t ? 4'd0 : sec_q[3:0] + 4'd1;
      if (c_sec_t) sec_d[7:4] = c_min   ? 4'd0 : sec_q[7:4] + 4'd1;
      if (c_min)   min_d[3:0] = c_min_t ? 4'd0 : min_q[3:0] + 4'd1;
      if (c_min_t) min_d[7:4] = c_hr    ? 4'd0 : min_q[7:4] + 4'd1;
      if (c_hr) begin
        if (MODE_24H) begin
          if (hr_q == 8'h23) begin
            hr_d       = 8'h00;
            day_tick_d = 1'b1;
          end else if (hr_q[3:0] == 4'd9) begin
            hr_d = {hr_q[7:4] + 4'd1, 4'd0};
          end else begin
            hr_d[3:0] = hr_q[3:0] + 4'd1;
          end
        end else begin
          // 12-hour face: 11 -> 12 flips AM/PM; midnight is PM -> AM.
          if (hr_q == 8'h12) begin
            hr_d = 8'h01;
          end else if (hr_q == 8'h11) begin
            hr_d       = 8'h12;
            pm_d       = ~pm_q;
            day_tick_d = pm_q;
          end else if (hr_q[3:0] == 4'd9) begin
            hr_d = {hr_q[7:4] + 4'd1, 4'd0};
          end else begin
            hr_d[3:0] = hr_q[3:0] + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hr_q       <= MODE_24H ? 8'h00 : 8'h12;
      min_q      <= '0;
      sec_q      <= '0;
      pm_q       <= 1'b0;
      day_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      pm_q       <= pm_d;
      day_tick_q <= day_tick_d;
      set_err_q  <= set_err_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.hr       = hr_q;
  assign bus.min      = min_q;
  assign bus.sec      = sec_q;
  assign bus.pm       = pm_q;
  assign bus.day_tick = day_tick_q;
  assign bus.set_err  = set_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Drives a 24-hour and a 12-hour counter with identical stimulus and checks
// both against a seconds-since-midnight reference model.
module tb_time_of_day_counter;
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  time_of_day_counter_if if24 ();
  time_of_day_counter_if if12 ();

  time_of_day_counter #(.MODE_24H(1'b1)) u24 (.clk(clk), .reset(reset), .bus(if24.slave));
  time_of_day_counter #(.MODE_24H(1'b0)) u12 (.clk(clk), .reset(reset), .bus(if12.slave));

  int tests = 0;
  int fails = 0;

  // Index 0 = 24-hour unit, 1 = 12-hour unit.
  int tod [2];
  bit exp_dt [2];
  bit exp_err [2];
  bit prev_tick;

  function automatic int b2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input int maxv);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (b2i(v) <= maxv);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      tod[k] = 0; exp_dt[k] = 1'b0; exp_err[k] = 1'b0;
    end
    prev_tick = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit r, input bit se,
                            input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input bit p);
    bit adv, valid;
    int h24;
    adv = t && !prev_tick && r && !se;
    prev_tick = t;
    for (int k = 0; k < 2; k++) begin
      exp_dt[k] = 1'b0;
      exp_err[k] = 1'b0;
      if (se) begin
        valid = bcd_ok(m, 59) && bcd_ok(s, 59) &&
                ((k == 0) ? bcd_ok(h, 23) : (bcd_ok(h, 12) && b2i(h) >= 1));
        if (valid) begin
          h24 = (k == 0) ? b2i(h) : (b2i(h) % 12) + (p ? 12 : 0);
          tod[k] = h24 * 3600 + b2i(m) * 60 + b2i(s);
        end else begin
          exp_err[k] = 1'b1;
        end
      end else if (adv) begin
        tod[k] = tod[k] + 1;
        if (tod[k] == 86400) begin
          tod[k] = 0;
          exp_dt[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    int h24, h12;
    h24 = tod[0] / 3600;
    chk("24h hr",  if24.hr,  i2b(h24));
    chk("24h min", if24.min, i2b((tod[0] / 60) % 60));
    chk("24h sec", if24.sec, i2b(tod[0] % 60));
    chk("24h pm",  {7'd0, if24.pm}, 8'd0);
    chk("24h day_tick", {7'd0, if24.day_tick}, {7'd0, exp_dt[0]});
    chk("24h set_err",  {7'd0, if24.set_err},  {7'd0, exp_err[0]});
    h24 = tod[1] / 3600;
    h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    chk("12h hr",  if12.hr,  i2b(h12));
    chk("12h min", if12.min, i2b((tod[1] / 60) % 60));
    chk("12h sec", if12.sec, i2b(tod[1] % 60));
    chk("12h pm",  {7'd0, if12.pm}, {7'd0, (h24 >= 12)});
    chk("12h day_tick", {7'd0, if12.day_tick}, {7'd0, exp_dt[1]});
    chk("12h set_err",  {7'd0, if12.set_err},  {7'd0, exp_err[1]});
  endtask

  task automatic drive(input bit t, input bit r, input bit se,
                       input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input bit p);
    if24.tick = t; if24.run = r; if24.set_en = se;
    if24.set_hr = h; if24.set_min = m; if24.set_sec = s; if24.set_pm = p;
    if12.tick = t; if12.run = r; if12.set_en = se;
    if12.set_hr = h; if12.set_min = m; if12.set_sec = s; if12.set_pm = p;
  endtask

  // One clock: apply inputs, update model, sample #1 after the edge.
  task automatic step(input bit t, input bit r, input bit se,
                      input logic [7:0] h, input logic [7:0] m,
                      input logic [7:0] s, input bit p);
    drive(t, r, se, h, m, s, p);
    model_step(t, r, se, h, m, s, p);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic tick1();
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m,
                      input logic [7:0] s, input bit p);
    step(1'b0, 1'b1, 1'b1, h, m, s, p);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    model_reset();
    #15;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;

    repeat (3) tick1();

    load(8'h23, 8'h59, 8'h58, 1'b0);
    tick1();
    tick1();

    load(8'h11, 8'h59, 8'h59, 1'b0);
    tick1();
    load(8'h11, 8'h59, 8'h59, 1'b1);
    tick1();
    load(8'h12, 8'h59, 8'h59, 1'b1);
    tick1();

    load(8'h05, 8'h20, 8'h60, 1'b0);
    load(8'h05, 8'h5A, 8'h10, 1'b0);
    load(8'h24, 8'h00, 8'h00, 1'b0);
    load(8'h00, 8'h30, 8'h30, 1'b0);
    load(8'h13, 8'h00, 8'h00, 1'b0);

    step(1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    tick1();

    repeat (5) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    load(8'h07, 8'h30, 8'h15, 1'b0);
    tick1();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick1();

    for (int i = 0; i < 3000; i++) begin
      bit t, r, se, p;
      logic [7:0] h, m, s;
      t  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 7) != 0);
      se = ($urandom_range(0, 24) == 0);
      p  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        h = i2b($urandom_range(0, 23));
        m = i2b($urandom_range(57, 59));
        s = i2b($urandom_range(50, 59));
      end else begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end
      step(t, r, se, h, m, s, p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
